// File: rtl/wb_master_pkg.sv
// rtl/wb_master_pkg.sv - shared widths, FSM states and command record for the Wishbone command master
package wb_master_pkg;

    localparam int ADR_W = 27;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic             we;
        logic [SEL_W-1:0] sel;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
    } wb_cmd_t;

endpackage

// File: rtl/wb_cmd_master_if.sv
// rtl/wb_cmd_master_if.sv - Wishbone classic bus bundle with master/slave views
interface wb_cmd_master_if;
    import wb_master_pkg::*;

    logic             wb_cyc_o;
    logic             wb_stb_o;
    logic             wb_we_o;
    logic [SEL_W-1:0] wb_sel_o;
    logic [ADR_W-1:0] wb_adr_o;
    logic [DAT_W-1:0] wb_dat_o;
    logic [DAT_W-1:0] wb_dat_i;
    logic             wb_ack_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
        output wb_dat_i, wb_ack_i
    );

endinterface

// File: rtl/wb_cmd_fifo.sv
// rtl/wb_cmd_fifo.sv - synchronous command queue with registered occupancy count
module wb_cmd_fifo
    import wb_master_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  logic    pop,
    input  wb_cmd_t wr_data,
    output wb_cmd_t rd_data,
    output logic    full,
    output logic    empty
);
    localparam int PTR_W = $clog2(DEPTH);

    wb_cmd_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // Flags come straight from the registered count, so a pop never frees a slot in the same cycle.
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array: written only on an accepted push, contents are don't-care after a flush.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - queued Wishbone classic command master; ack timeout enabled by WB_MASTER_TIMEOUT_EN
module wb_cmd_master
    import wb_master_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [SEL_W-1:0] cmd_sel,
    input  logic [ADR_W-1:0] cmd_adr,
    input  logic [DAT_W-1:0] cmd_dat,
    wb_cmd_master_if.master  wb,
    output logic             rsp_valid,
    output logic [DAT_W-1:0] rsp_dat,
    output logic             rsp_err
);
    wb_state_e        state;
    wb_state_e        state_next;
    wb_cmd_t          cmd_in;
    wb_cmd_t          fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             timeout_hit;
    logic             we_q;
    logic [SEL_W-1:0] sel_q;
    logic [ADR_W-1:0] adr_q;
    logic [DAT_W-1:0] dat_q;
    logic [DAT_W-1:0] rsp_dat_q;

    assign cmd_ready = !fifo_full && !reset;
    assign fifo_push = cmd_valid && cmd_ready;
    assign cmd_in    = '{we: cmd_we, sel: cmd_sel, adr: cmd_adr, dat: cmd_dat};

    wb_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk_100MHz),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (cmd_in),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;

    assign timeout_hit = (state == REQ) && !wb.wb_ack_i
                         && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign rsp_err     = err_q;

    // Counts completed REQ cycles of the current transaction; restarts whenever the bus is not requesting.
    always_ff @(posedge clk_100MHz) begin
        if (reset || state != REQ) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Error flag for the response: set on an abandoned request, cleared by a real ack.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (state == REQ && wb.wb_ack_i) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg  = ^TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and queue pop; ack only matters while a request is on the bus.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (wb.wb_ack_i || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus attribute registers, loaded only on pop so they stay frozen for the whole request.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            we_q  <= 1'b0;
            sel_q <= '0;
            adr_q <= '0;
            dat_q <= '0;
        end else if (fifo_pop) begin
            we_q  <= fifo_head.we;
            sel_q <= fifo_head.sel;
            adr_q <= fifo_head.adr;
            dat_q <= fifo_head.we ? fifo_head.dat : '0;
        end
    end

    // Response data: read data on ack, zero for writes and for abandoned requests.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            rsp_dat_q <= '0;
        end else if (state == REQ && wb.wb_ack_i) begin
            rsp_dat_q <= we_q ? '0 : wb.wb_dat_i;
        end else if (timeout_hit) begin
            rsp_dat_q <= '0;
        end
    end

    assign wb.wb_cyc_o = (state == REQ);
    assign wb.wb_stb_o = (state == REQ);
    assign wb.wb_we_o  = we_q;
    assign wb.wb_sel_o = sel_q;
    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign rsp_valid   = (state == DONE);
    assign rsp_dat     = rsp_dat_q;

endmodule
